// File: rtl/char_lcd_bus.sv
`default_nettype none
// ==========================================================================
// Module   : char_lcd_bus
// Purpose  : HD44780/WS0010 character-display bus engine timed in clk_48mhz cycles.
// Revision : 1.0
// ==========================================================================
module char_lcd_bus #(
  parameter int BUS_WIDTH    = 8,
  parameter int SETUP_CYCLES = 4,
  parameter int E_CYCLES     = 24,
  parameter int HOLD_CYCLES  = 24,
  parameter int POR_CYCLES   = 2400000,
  parameter int BUSY_TIMEOUT = 4096
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic       cmd_read,
  input  logic       cmd_poll,
  input  logic       cmd_nibble,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       timeout,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] db_out,
  output logic       db_oe,
  input  logic [7:0] db_in
);

  localparam int MAX_SE = (SETUP_CYCLES > E_CYCLES) ? SETUP_CYCLES : E_CYCLES;
  localparam int MAX_HP = (HOLD_CYCLES > POR_CYCLES) ? HOLD_CYCLES : POR_CYCLES;
  localparam int MAX_C  = (MAX_SE > MAX_HP) ? MAX_SE : MAX_HP;
  localparam int CW     = $clog2(MAX_C + 1);
  localparam int PW     = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] E_LAST     = CW'(E_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] POR_LAST   = CW'(POR_CYCLES - 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(BUSY_TIMEOUT - 1);
  localparam bit            NARROW     = (BUS_WIDTH == 4);

  typedef enum logic [2:0] {
    S_POR   = 3'd0,
    S_IDLE  = 3'd1,
    S_SETUP = 3'd2,
    S_EHI   = 3'd3,
    S_ELO   = 3'd4
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_polls;
  logic          r_read;
  logic          r_poll;
  logic          r_nibble;
  logic          r_polling;
  logic          r_strobe;
  logic          r_busy;
  logic [7:0]    r_data;
  logic [7:0]    r_rbuf;

  logic [7:0]    w_din;
  logic [7:0]    w_first;
  logic          w_last_strobe;

  // In 4-bit mode only the upper pad nibble is wired to the display.
  assign w_din         = NARROW ? {db_in[7:4], 4'h0} : db_in;
  assign w_first       = NARROW ? {cmd_data[7:4], 4'h0} : cmd_data;
  assign w_last_strobe = r_strobe || !NARROW || (r_nibble && !r_polling);
  assign cmd_ready     = (r_state == S_IDLE);

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      r_state   <= S_POR;
      r_cnt     <= '0;
      r_polls   <= '0;
      r_read    <= 1'b0;
      r_poll    <= 1'b0;
      r_nibble  <= 1'b0;
      r_polling <= 1'b0;
      r_strobe  <= 1'b0;
      r_busy    <= 1'b0;
      r_data    <= 8'h00;
      r_rbuf    <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      timeout   <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_rw    <= 1'b1;
      lcd_e     <= 1'b0;
      db_out    <= 8'h00;
      db_oe     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        S_POR: begin
          if (r_cnt == POR_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_IDLE: begin
          if (cmd_valid) begin
            r_read    <= cmd_read;
            r_poll    <= cmd_poll;
            r_nibble  <= NARROW && cmd_nibble;
            r_data    <= cmd_data;
            r_rbuf    <= 8'h00;
            r_polling <= 1'b0;
            r_strobe  <= 1'b0;
            timeout   <= 1'b0;
            lcd_rs    <= cmd_rs;
            lcd_rw    <= cmd_read;
            db_oe     <= !cmd_read;
            db_out    <= w_first;
            r_cnt     <= '0;
            r_state   <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (r_cnt == SETUP_LAST) begin
            r_cnt   <= '0;
            lcd_e   <= 1'b1;
            r_state <= S_EHI;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_EHI: begin
          if (r_cnt == E_LAST) begin
            r_cnt   <= '0;
            lcd_e   <= 1'b0;
            r_state <= S_ELO;
            // Bus is sampled on the last cycle E is high.
            if (!r_strobe) begin
              r_busy <= w_din[7];
              r_rbuf <= w_din;
            end else begin
              r_rbuf[3:0] <= w_din[7:4];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_ELO: begin
          if (r_cnt == HOLD_LAST) begin
            r_cnt <= '0;
            if (!w_last_strobe) begin
              r_strobe <= 1'b1;
              db_out   <= r_polling ? 8'h00 : {r_data[3:0], 4'h0};
              r_state  <= S_SETUP;
            end else begin
              r_strobe <= 1'b0;
              if (!r_polling && r_read) begin
                rsp_valid <= 1'b1;
                rsp_data  <= r_rbuf;
              end
              if ((!r_polling && r_poll && !r_nibble) ||
                  (r_polling && r_busy && r_polls != POLL_LAST)) begin
                r_polls   <= r_polling ? r_polls + 1'b1 : '0;
                r_polling <= 1'b1;
                lcd_rs    <= 1'b0;
                lcd_rw    <= 1'b1;
                db_oe     <= 1'b0;
                db_out    <= 8'h00;
                r_state   <= S_SETUP;
              end else begin
                if (r_polling && r_busy) begin
                  timeout <= 1'b1;
                end
                r_polling <= 1'b0;
                lcd_rs    <= 1'b0;
                lcd_rw    <= 1'b1;
                db_oe     <= 1'b0;
                r_state   <= S_IDLE;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: r_state <= S_POR;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_char_lcd_bus.sv
`default_nettype none
// ==========================================================================
// Module   : tb_char_lcd_bus
// Purpose  : Directed bench for char_lcd_bus, 8-bit and 4-bit instances.
// Revision : 1.0
// ==========================================================================
module tb_char_lcd_bus;

  logic       clk_48mhz = 1'b0;
  logic       reset     = 1'b1;

  logic       cmd_valid8 = 1'b0, cmd_rs8 = 1'b0, cmd_read8 = 1'b0;
  logic       cmd_poll8 = 1'b0, cmd_nibble8 = 1'b0;
  logic [7:0] cmd_data8 = 8'h00, db_in8 = 8'h00;
  logic       cmd_ready8, rsp_valid8, timeout8, lcd_rs8, lcd_rw8, lcd_e8, db_oe8;
  logic [7:0] rsp_data8, db_out8;

  logic       cmd_valid4 = 1'b0, cmd_rs4 = 1'b0, cmd_read4 = 1'b0;
  logic       cmd_poll4 = 1'b0, cmd_nibble4 = 1'b0;
  logic [7:0] cmd_data4 = 8'h00, db_in4 = 8'h00;
  logic       cmd_ready4, rsp_valid4, timeout4, lcd_rs4, lcd_rw4, lcd_e4, db_oe4;
  logic [7:0] rsp_data4, db_out4;

  int n_checks = 0;
  int n_errors = 0;

  // Observations gathered by run_cmd.
  int         n_rise, n_rd, n_rsp, viol, cyc;
  logic [7:0] d_first, d_second, rsp_seen;

  always #5 clk_48mhz = ~clk_48mhz;

  char_lcd_bus #(
    .BUS_WIDTH(8), .SETUP_CYCLES(2), .E_CYCLES(4), .HOLD_CYCLES(4),
    .POR_CYCLES(10), .BUSY_TIMEOUT(3)
  ) u_dut8 (
    .clk_48mhz(clk_48mhz), .reset(reset),
    .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8), .cmd_rs(cmd_rs8),
    .cmd_read(cmd_read8), .cmd_poll(cmd_poll8), .cmd_nibble(cmd_nibble8),
    .cmd_data(cmd_data8), .rsp_valid(rsp_valid8), .rsp_data(rsp_data8),
    .timeout(timeout8), .lcd_rs(lcd_rs8), .lcd_rw(lcd_rw8), .lcd_e(lcd_e8),
    .db_out(db_out8), .db_oe(db_oe8), .db_in(db_in8)
  );

  char_lcd_bus #(
    .BUS_WIDTH(4), .SETUP_CYCLES(2), .E_CYCLES(4), .HOLD_CYCLES(4),
    .POR_CYCLES(10), .BUSY_TIMEOUT(3)
  ) u_dut4 (
    .clk_48mhz(clk_48mhz), .reset(reset),
    .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4), .cmd_rs(cmd_rs4),
    .cmd_read(cmd_read4), .cmd_poll(cmd_poll4), .cmd_nibble(cmd_nibble4),
    .cmd_data(cmd_data4), .rsp_valid(rsp_valid4), .rsp_data(rsp_data4),
    .timeout(timeout4), .lcd_rs(lcd_rs4), .lcd_rw(lcd_rw4), .lcd_e(lcd_e4),
    .db_out(db_out4), .db_oe(db_oe4), .db_in(db_in4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_48mhz);
    #1;
  endtask

  // Reset has just been released in the current cycle (cycle 0).
  task automatic por_check(input bit both);
    for (int c = 0; c <= 10; c++) begin
      check("por_ready8", 32'(cmd_ready8), 32'(c == 10));
      check("por_e8", 32'(lcd_e8), 32'd0);
      check("por_oe8", 32'(db_oe8), 32'd0);
      if (both) begin
        check("por_ready4", 32'(cmd_ready4), 32'(c == 10));
        check("por_oe4", 32'(db_oe4), 32'd0);
      end
      if (c < 10) tick();
    end
  endtask

  task automatic send(input bit sel, input logic rs, input logic rd, input logic poll,
                      input logic nib, input logic [7:0] d);
    int w = 0;
    while (!(sel ? cmd_ready4 : cmd_ready8) && w < 200) begin
      tick();
      w++;
    end
    check("send_ready", 32'(sel ? cmd_ready4 : cmd_ready8), 32'd1);
    if (sel) begin
      cmd_rs4 = rs; cmd_read4 = rd; cmd_poll4 = poll; cmd_nibble4 = nib;
      cmd_data4 = d; cmd_valid4 = 1'b1;
    end else begin
      cmd_rs8 = rs; cmd_read8 = rd; cmd_poll8 = poll; cmd_nibble8 = nib;
      cmd_data8 = d; cmd_valid8 = 1'b1;
    end
    tick();
    cmd_valid4 = 1'b0;
    cmd_valid8 = 1'b0;
  endtask

  // Steps from cycle 1 after accept until cmd_ready, acting as the display.
  // mode 0: busy on polls 1-2; 1: busy stuck; 2: nibble read A/5;
  // mode 3: 4-bit busy on first strobe of polls 1-2, decoy busy on poll 3 second strobe.
  task automatic run_cmd(input bit sel, input int mode);
    logic e, pe, rw, oe, rdy, rv;
    logic [7:0] dout, rd;
    n_rise = 0; n_rd = 0; n_rsp = 0; viol = 0; cyc = 0; pe = 1'b0;
    forever begin
      e    = sel ? lcd_e4     : lcd_e8;
      rw   = sel ? lcd_rw4    : lcd_rw8;
      oe   = sel ? db_oe4     : db_oe8;
      rdy  = sel ? cmd_ready4 : cmd_ready8;
      rv   = sel ? rsp_valid4 : rsp_valid8;
      dout = sel ? db_out4    : db_out8;
      rd   = sel ? rsp_data4  : rsp_data8;
      if (e && !pe) begin
        n_rise++;
        if (rw) n_rd++;
        if (n_rise == 1) d_first = dout;
        if (n_rise == 2) d_second = dout;
      end
      if (oe && rw) viol++;
      if (rv) begin
        n_rsp++;
        rsp_seen = rd;
      end
      pe = e;
      if (rdy || cyc >= 400) break;
      case (mode)
        0: db_in8 = (n_rd >= 1 && n_rd <= 2) ? 8'h80 : 8'h00;
        1: db_in8 = 8'h80;
        2: db_in4 = (n_rise == 1) ? 8'hAF : (n_rise == 2) ? 8'h5C : 8'h00;
        3: db_in4 = (((n_rd % 2) == 1 && n_rd <= 3) || n_rd == 6) ? 8'h80 : 8'h00;
        default: ;
      endcase
      tick();
      cyc++;
    end
    check("run_bound", 32'(cyc < 400), 32'd1);
    check("oe_rw_excl", 32'(viol), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("rst_rw", 32'(lcd_rw8), 32'd1);
    check("rst_ready", 32'(cmd_ready8), 32'd0);
    check("rst_rsp", 32'(rsp_data8), 32'd0);
    reset = 1'b0;
    por_check(1'b1);

    // 8-bit write 0x41, rs=1, no poll: cycle-accurate pin timing.
    send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h41);
    cmd_data8 = 8'hFF;
    cmd_rs8   = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      check("w8_e", 32'(lcd_e8), 32'(c >= 3 && c <= 6));
      check("w8_ready", 32'(cmd_ready8), 32'(c == 11));
      if (c <= 10) begin
        check("w8_rs", 32'(lcd_rs8), 32'd1);
        check("w8_rw", 32'(lcd_rw8), 32'd0);
        check("w8_oe", 32'(db_oe8), 32'd1);
        check("w8_data", 32'(db_out8), 32'h41);
      end else begin
        check("w8_idle_oe", 32'(db_oe8), 32'd0);
        check("w8_idle_rw", 32'(lcd_rw8), 32'd1);
      end
      if (c < 11) tick();
    end

    // Write then poll; busy for two polls.
    send(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
    run_cmd(1'b0, 0);
    check("poll_strobes", 32'(n_rd), 32'd3);
    check("poll_total", 32'(n_rise), 32'd4);
    check("poll_cycles", 32'(cyc), 32'd40);
    check("poll_timeout", 32'(timeout8), 32'd0);
    check("poll_idle_rw", 32'(lcd_rw8), 32'd1);
    check("poll_idle_rs", 32'(lcd_rs8), 32'd0);

    // Busy stuck: timeout after three polls, cleared on next accept.
    send(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02);
    run_cmd(1'b0, 1);
    check("stuck_strobes", 32'(n_rd), 32'd3);
    check("stuck_cycles", 32'(cyc), 32'd40);
    check("stuck_timeout", 32'(timeout8), 32'd1);
    check("stuck_ready", 32'(cmd_ready8), 32'd1);
    send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0C);
    check("timeout_clear", 32'(timeout8), 32'd0);
    run_cmd(1'b0, 1);
    check("tclr_cycles", 32'(cyc), 32'd10);

    // 4-bit read: nibbles A then 5.
    send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    run_cmd(1'b1, 2);
    check("r4_strobes", 32'(n_rise), 32'd2);
    check("r4_cycles", 32'(cyc), 32'd20);
    check("r4_pulses", 32'(n_rsp), 32'd1);
    check("r4_data", 32'(rsp_seen), 32'hA5);
    tick();
    check("r4_pulse_end", 32'(rsp_valid4), 32'd0);
    check("r4_hold", 32'(rsp_data4), 32'hA5);

    // 4-bit full write: high then low nibble on db_out[7:4].
    send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5C);
    run_cmd(1'b1, 2);
    check("w4_strobes", 32'(n_rise), 32'd2);
    check("w4_first", 32'(d_first), 32'h50);
    check("w4_second", 32'(d_second), 32'hC0);

    // Nibble write with poll requested: single strobe, no poll.
    send(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h30);
    run_cmd(1'b1, 2);
    check("nib_strobes", 32'(n_rise), 32'd1);
    check("nib_data", 32'(d_first), 32'h30);
    check("nib_cycles", 32'(cyc), 32'd10);
    check("nib_nopoll", 32'(n_rd), 32'd0);

    // 4-bit poll: busy taken from first strobe only; both strobes issued.
    send(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
    run_cmd(1'b1, 3);
    check("p4_strobes", 32'(n_rd), 32'd6);
    check("p4_cycles", 32'(cyc), 32'd80);
    check("p4_timeout", 32'(timeout4), 32'd0);

    // Reset during E-high aborts and restarts power-on hold-off.
    send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
    repeat (3) tick();
    check("rst_mid_e_before", 32'(lcd_e8), 32'd1);
    reset = 1'b1;
    tick();
    check("rst_mid_e", 32'(lcd_e8), 32'd0);
    check("rst_mid_oe", 32'(db_oe8), 32'd0);
    check("rst_mid_ready", 32'(cmd_ready8), 32'd0);
    reset = 1'b0;
    por_check(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/char_lcd_bus.md
Name: char_lcd_bus

Overview:
- Parametrised HD44780/WS0010-compatible character-display bus engine running directly on clk_48mhz.
- All bus timing comes from cycle-count parameters; no divided fabric clocks.
- Supports 8-bit or 4-bit bus, write/read transfers, busy-flag polling with timeout, and a power-on hold-off.
- Sits between a display sequencer (valid/ready command stream) and the top-level SB_IO tristate buffers.

Parameters:
- BUS_WIDTH, 8, 8 or 4; 4 uses db_out[7:4]/db_in[7:4] only.
- SETUP_CYCLES, 4, cycles RS/RW/data are stable before E rises (min 1).
- E_CYCLES, 24, cycles E is held high per strobe (min 1).
- HOLD_CYCLES, 24, cycles E is low after a strobe with RS/RW/data unchanged (min 1).
- POR_CYCLES, 2400000, cycles after reset before first cmd_ready (50 ms at 48 MHz; min 1).
- BUSY_TIMEOUT, 4096, max busy polls per command before abort (min 1).

Ports:
- clk_48mhz  in  1  system clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine idle, accepts command
- cmd_rs  in  1  register select (0 = instruction, 1 = data)
- cmd_read  in  1  1 = read transfer, 0 = write
- cmd_poll  in  1  poll busy flag after the transfer
- cmd_nibble  in  1  4-bit mode only: single strobe of cmd_data[7:4]; ignored when BUS_WIDTH=8
- cmd_data  in  8  write data
- rsp_valid  out  1  one-cycle pulse: read data available
- rsp_data  out  8  last read byte; held until next read completes
- timeout  out  1  sticky: busy poll exhausted; cleared when the next command is accepted
- lcd_rs  out  1  RS pin
- lcd_rw  out  1  R/!W pin
- lcd_e  out  1  E pin
- db_out  out  8  data to pads
- db_oe  out  1  pad output enable
- db_in  in  8  data from pads

Behaviour:
- Reset values: lcd_e=0, lcd_rw=1, lcd_rs=0, db_out=0, db_oe=0, cmd_ready=0, rsp_valid=0, rsp_data=0, timeout=0.
- Reset mid-transfer aborts immediately (E drops the next edge) and restarts the POR count.
- States: POR → IDLE → XFER (SETUP → EHI → ELO, repeated per strobe) → POLL (same sub-phases) → IDLE.
- POR: counts POR_CYCLES, then IDLE. cmd_ready = (state==IDLE) only.
- Accept on the edge where cmd_valid && cmd_ready. From the next cycle, for each strobe:
  - lcd_rs = cmd_rs, lcd_rw = cmd_read, db_oe = !cmd_read for SETUP_CYCLES with E low;
  - then E high for E_CYCLES;
  - then E low for HOLD_CYCLES.
- Command fields are latched at accept; later input changes are ignored.
- Strobes per transfer:
  - BUS_WIDTH=8: 1 strobe, db_out = data.
  - BUS_WIDTH=4: 2 strobes, high nibble then low, on db_out[7:4]; db_out[3:0]=0.
  - BUS_WIDTH=4 with cmd_nibble=1: 1 strobe, high nibble.
- Read: db_in is sampled on the last E-high cycle of each strobe; 4-bit reads assemble {first,second} nibble. rsp_valid pulses on the cycle after the final HOLD cycle.
- POLL (cmd_poll=1), entered after the final HOLD cycle:
  - rs=0, rw=1, db_oe=0; db_oe falls on the first POLL SETUP cycle.
  - Busy = db_in[7] from the first strobe of each poll. In 4-bit mode the second strobe is always issued.
  - Busy=0 → IDLE. Busy=1 → poll again.
  - After BUSY_TIMEOUT polls all busy: set timeout, go IDLE.
  - cmd_nibble commands never poll.
- Return to IDLE: lcd_rw=1, db_oe=0, lcd_rs=0; cmd_ready rises that cycle.
- 8-bit transfer without poll: accept edge at cycle 0 → cmd_ready high at cycle SETUP+E+HOLD+1.
- Counters are sized with $clog2 of the largest parameter; no wrap-around occurs within a phase.
- db_oe and lcd_rw are never both "drive" (db_oe=1 implies lcd_rw=0) on any cycle.

Test Plan:
- Bench parameters: SETUP=2, E=4, HOLD=4, POR=10, TIMEOUT=3.
- POR: deassert reset at cycle 0 → cmd_ready=0 through cycle 9, 1 at cycle 10; lcd_e=0, db_oe=0 throughout.
- 8-bit write 0x41, rs=1, no poll, accepted at cycle 0 → lcd_rs=1, db_oe=1, db_out=0x41 cycles 1–10; lcd_e=1 cycles 3–6; cmd_ready=1 at cycle 11.
- 8-bit write then poll; model drives db_in[7]=1 for 2 polls then 0 → exactly 3 poll strobes with rw=1 and db_oe=0; timeout=0; return to IDLE.
- Busy stuck at 1 → 3 polls, timeout=1 and cmd_ready=1 after them; next accepted command clears timeout.
- BUS_WIDTH=4: read with db_in[7:4]=0xA then 0x5 → 2 strobes, rsp_valid one pulse, rsp_data=0xA5. cmd_nibble write 0x30 → single strobe, db_out=0x30.
- Reset asserted during E-high → next cycle lcd_e=0, db_oe=0, cmd_ready=0; POR count restarts (cmd_ready after 10 cycles).
